// File: rtl/wisc_pkg.sv
// wisc_pkg: shared register-file geometry and write-back state encoding
package wisc_pkg;
    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 4;
    localparam int NUM_REGS   = 2 ** REG_ADDR_W;
    typedef enum logic {RUN = 1'b0, HALTED = 1'b1} wb_state_t;
endpackage

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: MEM-side capture inputs and register-file write/bypass outputs
interface mem_wb_stage_if #(
    parameter int DATA_W     = wisc_pkg::DATA_W,
    parameter int REG_ADDR_W = wisc_pkg::REG_ADDR_W,
    parameter int NUM_REGS   = 2 ** REG_ADDR_W
);
    logic                  in_valid;
    logic                  in_reg_write;
    logic                  in_mem_to_reg;
    logic                  in_halt;
    logic [REG_ADDR_W-1:0] in_rd;
    logic [DATA_W-1:0]     in_alu_result;
    logic [DATA_W-1:0]     in_mem_data;
    logic                  stall;
    logic                  flush;
    logic [REG_ADDR_W-1:0] rd_addr1;
    logic [REG_ADDR_W-1:0] rd_addr2;
    logic [NUM_REGS-1:0]   wr_en_row;
    logic [DATA_W-1:0]     wr_data;
    logic                  byp_hit1;
    logic                  byp_hit2;
    logic [DATA_W-1:0]     byp_data;
    logic                  halted;
    logic [31:0]           retire_cnt;
    modport master (
        output in_valid, in_reg_write, in_mem_to_reg, in_halt, in_rd, in_alu_result, in_mem_data,
        output stall, flush, rd_addr1, rd_addr2,
        input  wr_en_row, wr_data, byp_hit1, byp_hit2, byp_data, halted, retire_cnt
    );
    modport slave (
        input  in_valid, in_reg_write, in_mem_to_reg, in_halt, in_rd, in_alu_result, in_mem_data,
        input  stall, flush, rd_addr1, rd_addr2,
        output wr_en_row, wr_data, byp_hit1, byp_hit2, byp_data, halted, retire_cnt
    );
endinterface

// File: rtl/mem_wb_stage_row_decoder.sv
// row_decoder: register index to one-hot row select, all-zero when disabled
module row_decoder #(
    parameter int ADDR_W = 4,
    parameter int ROWS   = 2 ** ADDR_W
) (
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic [ROWS-1:0]   row
);
    assign row = en ? ROWS'(1) << addr : '0;
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB register, register-file write driver, bypass and halt tracking; MEM_WB_RETIRE_CNT_EN adds a retire counter
module mem_wb_stage import wisc_pkg::*; #(
    parameter int DATA_W     = wisc_pkg::DATA_W,
    parameter int REG_ADDR_W = wisc_pkg::REG_ADDR_W,
    parameter int NUM_REGS   = 2 ** REG_ADDR_W
) (
    input logic           clk,
    input logic           rst,
    mem_wb_stage_if.slave bus
);
    wb_state_t             state, state_nxt;
    logic                  v, rw, m2r, hlt;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     alu, mdat;
    logic                  go_halt, wr_active;

    assign go_halt = state == RUN && v && hlt && !bus.flush;

    // State register
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= RUN;
        else state <= state_nxt;

    // HALTED is terminal until reset
    always_comb state_nxt = go_halt ? HALTED : state;

    // Write qualification and halt flag; r0 is hardwired so never written
    always_comb begin
        bus.halted = state == HALTED;
        wr_active  = state == RUN && v && rw && !hlt && rd != '0;
    end

    // Stage capture: flush or halt only kill valid, stall holds everything
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            v    <= 1'b0;
            rw   <= 1'b0;
            m2r  <= 1'b0;
            hlt  <= 1'b0;
            rd   <= '0;
            alu  <= '0;
            mdat <= '0;
        end else if (state == HALTED || go_halt || bus.flush) v <= 1'b0;
        else if (!bus.stall) begin
            v    <= bus.in_valid;
            rw   <= bus.in_reg_write;
            m2r  <= bus.in_mem_to_reg;
            hlt  <= bus.in_halt;
            rd   <= bus.in_rd;
            alu  <= bus.in_alu_result;
            mdat <= bus.in_mem_data;
        end

    row_decoder #(.ADDR_W(REG_ADDR_W), .ROWS(NUM_REGS)) u_dec (
        .en   (wr_active),
        .addr (rd),
        .row  (bus.wr_en_row)
    );

    assign bus.wr_data  = m2r ? mdat : alu;
    assign bus.byp_data = bus.wr_data;
    assign bus.byp_hit1 = wr_active && bus.rd_addr1 == rd;
    assign bus.byp_hit2 = wr_active && bus.rd_addr2 == rd;

`ifdef MEM_WB_RETIRE_CNT_EN
    logic [31:0] cnt;

    // Count retirements while running; frozen once halted
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else if (state == RUN && v && !bus.stall) cnt <= cnt + 32'd1;

    assign bus.retire_cnt = cnt;
`else
    assign bus.retire_cnt = '0;
`endif
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed and random checks of mem_wb_stage against a behavioural model
module tb_mem_wb_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_wb_stage_if bus ();
    mem_wb_stage dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        bit        v, rw, m2r, hlt;
        bit [3:0]  rd;
        bit [15:0] alu, mdat;
    } slot_t;

    slot_t     s;
    bit        m_halted;
    bit [31:0] m_cnt;
    int        n_vec = 0;
    int        n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit [31:0] exp_cnt();
`ifdef MEM_WB_RETIRE_CNT_EN
        return m_cnt;
`else
        return 32'd0;
`endif
    endfunction

    function automatic void model_reset();
        s = '{default: 0};
        m_halted = 1'b0;
        m_cnt = 32'd0;
    endfunction

    function automatic void model_edge();
        if (m_halted) return;
        if (s.v && !bus.stall) m_cnt = m_cnt + 1;
        if (s.v && s.hlt && !bus.flush) begin
            m_halted = 1'b1;
            s.v = 1'b0;
        end else if (bus.flush) s.v = 1'b0;
        else if (!bus.stall)
            s = '{bus.in_valid, bus.in_reg_write, bus.in_mem_to_reg, bus.in_halt,
                  bus.in_rd, bus.in_alu_result, bus.in_mem_data};
    endfunction

    task automatic check_all();
        bit        a;
        bit [15:0] d;
        a = !m_halted && s.v && s.rw && !s.hlt && s.rd != 0;
        d = s.m2r ? s.mdat : s.alu;
        chk("wr_en_row", 32'(bus.wr_en_row), a ? 32'd1 << s.rd : 32'd0);
        chk("wr_data", 32'(bus.wr_data), 32'(d));
        chk("byp_data", 32'(bus.byp_data), 32'(d));
        chk("byp_hit1", 32'(bus.byp_hit1), 32'(a && bus.rd_addr1 == s.rd));
        chk("byp_hit2", 32'(bus.byp_hit2), 32'(a && bus.rd_addr2 == s.rd));
        chk("halted", 32'(bus.halted), 32'(m_halted));
        chk("retire_cnt", bus.retire_cnt, exp_cnt());
    endtask

    task automatic drive(input bit v, rw, m2r, hlt, input bit [3:0] rd,
                         input bit [15:0] alu, mdat, input bit stall, flush);
        bus.in_valid      = v;
        bus.in_reg_write  = rw;
        bus.in_mem_to_reg = m2r;
        bus.in_halt       = hlt;
        bus.in_rd         = rd;
        bus.in_alu_result = alu;
        bus.in_mem_data   = mdat;
        bus.stall         = stall;
        bus.flush         = flush;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic mid_reset();
        #2 rst = 1'b0;
        #1 model_reset();
        chk("rst_row", 32'(bus.wr_en_row), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        chk("rst_cnt", bus.retire_cnt, 32'd0);
        check_all();
        @(negedge clk) rst = 1'b1;
    endtask

    initial begin
        int idle;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.rd_addr1 = 0;
        bus.rd_addr2 = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b1;

        drive(1, 1, 0, 0, 5, 16'hBEEF, 16'h0000, 0, 0);
        step();
        chk("t1_row", 32'(bus.wr_en_row), 32'h0020);
        chk("t1_data", 32'(bus.wr_data), 32'hBEEF);

        drive(1, 1, 1, 0, 3, 16'h5555, 16'h1234, 0, 0);
        bus.rd_addr1 = 3;
        bus.rd_addr2 = 4;
        step();
        chk("t2_hit1", 32'(bus.byp_hit1), 32'd1);
        chk("t2_hit2", 32'(bus.byp_hit2), 32'd0);
        chk("t2_byp", 32'(bus.byp_data), 32'h1234);

        drive(1, 1, 0, 0, 0, 16'hFFFF, 16'h0000, 0, 0);
        bus.rd_addr1 = 0;
        step();
        chk("t3_row", 32'(bus.wr_en_row), 32'd0);
        chk("t3_hit1", 32'(bus.byp_hit1), 32'd0);

        drive(1, 1, 0, 0, 7, 16'h0777, 16'h0000, 0, 0);
        step();
        drive(1, 1, 0, 0, 9, 16'h9999, 16'h0000, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_hold_row", 32'(bus.wr_en_row), 32'h0080);
        end
        drive(1, 1, 0, 0, 9, 16'h9999, 16'h0000, 1, 1);
        step();
        chk("t4_flush_row", 32'(bus.wr_en_row), 32'd0);

        drive(1, 1, 0, 1, 2, 16'h2222, 16'h0000, 0, 0);
        step();
        chk("t5_hlt_row", 32'(bus.wr_en_row), 32'd0);
        chk("t5_halted_pre", 32'(bus.halted), 32'd0);
        drive(1, 1, 0, 0, 4, 16'h4444, 16'h0000, 0, 0);
        step();
        chk("t5_halted", 32'(bus.halted), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_ignored_row", 32'(bus.wr_en_row), 32'd0);
        end

        mid_reset();
        drive(1, 1, 0, 0, 6, 16'h6666, 16'h0000, 0, 0);
        step();
        chk("t6_row", 32'(bus.wr_en_row), 32'h0040);
        mid_reset();

        idle = 0;
        for (int n = 0; n < 600; n++) begin
            drive($urandom % 4 != 0, 1'($urandom), 1'($urandom), $urandom % 40 == 0,
                  4'($urandom), 16'($urandom), 16'($urandom),
                  $urandom % 5 == 0, $urandom % 8 == 0);
            bus.rd_addr1 = $urandom % 2 ? bus.in_rd : 4'($urandom);
            bus.rd_addr2 = $urandom % 2 ? bus.in_rd : 4'($urandom);
            step();
            idle = m_halted ? idle + 1 : 0;
            if (idle > 8 || $urandom % 100 == 0) begin
                mid_reset();
                idle = 0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

MEM/WB pipeline register and write-back driver for the 16-entry register file. Captures the retiring instruction from the memory stage, selects write-back data, and drives the per-row `WriteEnable` one-hot and shared `D` bus into the register-file bit cells. Provides same-cycle read bypass so decode sees the value being written. Tracks processor halt and an optional retire counter.

## Interface
Parameters:
- `DATA_W`, 16, datapath / register width
- `REG_ADDR_W`, 4, register index width
- `NUM_REGS`, 16, rows driven, equal to 2**REG_ADDR_W

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  MEM stage holds a real instruction
- `in_reg_write`  in  1  instruction writes a register
- `in_mem_to_reg`  in  1  1: write load data, 0: write ALU result
- `in_halt`  in  1  instruction is HLT
- `in_rd`  in  REG_ADDR_W  destination register
- `in_alu_result`  in  DATA_W  ALU / PC-link result
- `in_mem_data`  in  DATA_W  load data
- `stall`  in  1  hold stage contents
- `flush`  in  1  invalidate captured instruction
- `rd_addr1`, `rd_addr2`  in  REG_ADDR_W  decode read addresses
- `wr_en_row`  out  NUM_REGS  one-hot row write enables (bit cell `WriteEnable`)
- `wr_data`  out  DATA_W  write data (bit cell `D`)
- `byp_hit1`, `byp_hit2`  out  1  read address matches active write
- `byp_data`  out  DATA_W  bypass value (equals `wr_data`)
- `halted`  out  1  HLT has retired; sticky
- `retire_cnt`  out  32  retired instruction count (macro-gated)

## Operation
- Stage registers: `v`, `rw`, `m2r`, `hlt`, `rd`, `alu`, `mdat`. All reset to 0.
- FSM: `RUN` (reset state), `HALTED`.
  - RUN, edge: `flush` -> `v`<=0; else `stall` -> hold; else capture all `in_*`.
  - RUN -> HALTED when `v && hlt` at a rising edge not overridden by `flush`; the HLT itself retires (counted), never writes.
  - HALTED: capture disabled, `v` forced 0, `halted`=1. Exit only by reset.
- `wr_active = v && rw && !hlt && (rd != 0) && state==RUN`. r0 is never written.
- `wr_data = m2r ? mdat : alu` (combinational from stage registers).
- `wr_en_row[i] = wr_active && (rd == i)`; at most one bit set.
- Bypass: `byp_hitN = wr_active && (rd_addrN == rd)`; `byp_data = wr_data`. Reading r0 never hits.
- `flush` and `stall` together: flush wins.
- Stage registers hold while `stall`=1, so `wr_en_row` stays asserted; rewriting the same value is harmless and required behaviour.

## Timing
- Capture latency 1 cycle: instruction presented at edge N drives `wr_en_row`/`wr_data` during cycle N..N+1; bit cell updates at edge N+1.
- Outputs are combinational from registers only (no input-to-output path except `rd_addrN` -> `byp_hitN`).
- Reset asserted mid-write: all registers clear asynchronously, `wr_en_row` drops to 0 within the same cycle; no partial write reaches the array on the next edge.
- `halted` rises the cycle after HLT is in the stage (1 cycle after capture).

## Configuration
- `MEM_WB_RETIRE_CNT_EN` defined: 32-bit counter, reset 0, +1 each edge in RUN when `v && !stall`; wraps 0xFFFFFFFF -> 0; frozen in HALTED.
- Undefined: no counter flops; `retire_cnt` tied to 0.

## Structure
- Shared package `wisc_pkg`: `DATA_W`, `REG_ADDR_W`, `NUM_REGS`, `wb_state_t` enum (`RUN`, `HALTED`).
- One sub-module: `row_decoder` (REG_ADDR_W -> NUM_REGS one-hot with enable), reusable for read-port decode.

## Test plan
- Reset, then capture `rd`=5, `rw`=1, `m2r`=0, `alu`=0xBEEF -> next cycle `wr_en_row`=0x0020, `wr_data`=0xBEEF.
- Load `rd`=3, `m2r`=1, `mdat`=0x1234, `rd_addr1`=3, `rd_addr2`=4 -> `byp_hit1`=1, `byp_hit2`=0, `byp_data`=0x1234.
- Write to `rd`=0 with `alu`=0xFFFF -> `wr_en_row`=0, bypass on `rd_addr1`=0 reads no hit.
- Stall 3 cycles then flush with stall still high -> `wr_en_row` held 3 cycles, then 0 after flush edge.
- HLT captured with `rw`=1 -> no write, `halted`=1 next cycle, later valid `rw` inputs ignored; `retire_cnt` (macro on) stops at HLT count.
- Assert `rst` low mid-write -> `wr_en_row`=0, `halted`=0, `retire_cnt`=0 immediately.
